// File: rtl/echo_delay_ctrl.sv
// Echo/feedback delay engine: one read-modify-write on a circular SPRAM buffer per sample.
// Define ECHO_CLEAR_EN to zero the whole buffer after every reset before accepting samples.
module echo_delay_ctrl #(
    parameter int DATALEN = 16,
    parameter int ADDRLEN = 16,
    parameter int FBLEN   = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               sample_valid,
    input  logic [DATALEN-1:0] sample_in,
    input  logic [ADDRLEN-1:0] delay,
    input  logic [FBLEN-1:0]   feedback,
    output logic [DATALEN-1:0] sample_out,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun,
    output logic [ADDRLEN-1:0] mem_addr,
    output logic [DATALEN-1:0] mem_datain,
    input  logic [DATALEN-1:0] mem_dataout,
    output logic               mem_wren
);

    localparam int PW = DATALEN + FBLEN + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_MIX,
`ifdef ECHO_CLEAR_EN
        S_CLEAR,
`endif
        S_WRITE
    } state_t;

    state_t r_state, w_next;

    logic [ADDRLEN-1:0] r_ptr, r_delay;
    logic [DATALEN-1:0] r_sample, r_dly, r_mix, r_sample_out;
    logic [FBLEN-1:0]   r_fb;
    logic               r_out_valid, r_overrun;
`ifdef ECHO_CLEAR_EN
    logic [ADDRLEN-1:0] r_clr_addr;
`endif

    logic signed [PW-1:0]        w_prod, w_shift;
    logic        [DATALEN+1:0]   w_sum;
    logic        [DATALEN-1:0]   w_mix;
    logic        [ADDRLEN:0]     w_ptr_inc;
    logic        [ADDRLEN-1:0]   w_next_ptr;

    // Signed sample times zero-extended gain, both widened so the product is exact.
    assign w_prod  = $signed({{(FBLEN+1){r_dly[DATALEN-1]}}, r_dly}) *
                     $signed({{(DATALEN+1){1'b0}}, r_fb});
    assign w_shift = w_prod >>> FBLEN;
    assign w_sum   = {{2{r_sample[DATALEN-1]}}, r_sample} + w_shift[DATALEN+1:0];

    always_comb begin
        w_mix = w_sum[DATALEN-1:0];
        if (w_sum[DATALEN+1:DATALEN-1] != '0 && w_sum[DATALEN+1:DATALEN-1] != '1)
            w_mix = w_sum[DATALEN+1] ? {1'b1, {(DATALEN-1){1'b0}}}
                                     : {1'b0, {(DATALEN-1){1'b1}}};
    end

    // Comparing ptr+1 against delay folds the delay=0 case into "wrap to 0".
    assign w_ptr_inc  = {1'b0, r_ptr} + 1'b1;
    assign w_next_ptr = (w_ptr_inc >= {1'b0, r_delay}) ? '0 : w_ptr_inc[ADDRLEN-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
`ifdef ECHO_CLEAR_EN
            r_state <= S_CLEAR;
`else
            r_state <= S_IDLE;
`endif
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        mem_addr   = r_ptr;
        mem_datain = '0;
        mem_wren   = 1'b0;
        case (r_state)
            S_IDLE:  if (sample_valid) w_next = S_READ;
            S_READ:  w_next = S_WAIT;
            S_WAIT:  w_next = S_MIX;
            S_MIX:   w_next = S_WRITE;
            S_WRITE: begin
                mem_datain = r_mix;
                mem_wren   = 1'b1;
                w_next     = S_IDLE;
            end
`ifdef ECHO_CLEAR_EN
            S_CLEAR: begin
                mem_addr = r_clr_addr;
                mem_wren = 1'b1;
                if (r_clr_addr == '1) w_next = S_IDLE;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ptr        <= '0;
            r_delay      <= '0;
            r_sample     <= '0;
            r_fb         <= '0;
            r_dly        <= '0;
            r_mix        <= '0;
            r_sample_out <= '0;
            r_out_valid  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef ECHO_CLEAR_EN
            r_clr_addr   <= '0;
`endif
        end else begin
            r_out_valid <= 1'b0;
            if (sample_valid && r_state != S_IDLE) r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: if (sample_valid) begin
                    r_sample <= sample_in;
                    r_delay  <= delay;
                    r_fb     <= feedback;
                end
                S_WAIT:  r_dly <= mem_dataout;
                S_MIX:   r_mix <= w_mix;
                S_WRITE: begin
                    r_sample_out <= r_mix;
                    r_out_valid  <= 1'b1;
                    r_ptr        <= w_next_ptr;
                end
`ifdef ECHO_CLEAR_EN
                S_CLEAR: r_clr_addr <= r_clr_addr + 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign sample_out = r_sample_out;
    assign out_valid  = r_out_valid;
    assign overrun    = r_overrun;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Randomized bench for echo_delay_ctrl against an arithmetic circular-buffer model.
module tb_echo_delay_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        sample_valid;
    logic [15:0] sample_in, delay, sample_out, mem_addr, mem_datain, mem_dataout;
    logic [7:0]  feedback;
    logic        out_valid, busy, overrun, mem_wren;

    echo_delay_ctrl dut (
        .clk(clk), .resetn(resetn), .sample_valid(sample_valid), .sample_in(sample_in),
        .delay(delay), .feedback(feedback), .sample_out(sample_out), .out_valid(out_valid),
        .busy(busy), .overrun(overrun), .mem_addr(mem_addr), .mem_datain(mem_datain),
        .mem_dataout(mem_dataout), .mem_wren(mem_wren)
    );

    always #5 clk = ~clk;

    // SPRAM model: registered read, write on wren.
    logic [15:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr] <= mem_datain;
        mem_dataout <= mem[mem_addr];
    end

    int n_pass = 0, n_chk = 0;
    int ref_mem [0:65535];
    int ref_ptr = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference: y = sat(x + floor(buf[ptr]*fb/256)); buf[ptr] = y; ptr advances mod max(delay,1).
    task automatic ref_step(input int s, input int d, input int fb, output int y, output int a);
        int p, q, len;
        p = ref_mem[ref_ptr] * fb;
        q = p / 256;
        if (p < 0 && (p % 256) != 0) q = q - 1;
        y = s + q;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        a = ref_ptr;
        ref_mem[ref_ptr] = y;
        len = (d == 0) ? 1 : d;
        ref_ptr = (ref_ptr + 1 >= len) ? 0 : ref_ptr + 1;
    endtask

    // Starts and ends on a falling edge; poke injects an extra strobe k cycles in (0 = none).
    task automatic do_sample(input int s, input int d, input int fb, input int poke);
        int y, a;
        ref_step(s, d, fb, y, a);
        sample_valid = 1'b1;
        sample_in    = 16'(s);
        delay        = 16'(d);
        feedback     = 8'(fb);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            sample_valid = (k == poke);
            if (k < 4) chk("wren_early", int'(mem_wren), 0);
            if (k < 5) chk("busy", int'(busy), 1);
            if (k < 5) chk("ovalid_early", int'(out_valid), 0);
            if (k == 4) begin
                chk("wren_write", int'(mem_wren), 1);
                chk("waddr", int'(mem_addr), a);
                chk("wdata", int'($signed(mem_datain)), y);
            end
            if (k == 5) begin
                chk("ovalid", int'(out_valid), 1);
                chk("sample_out", int'($signed(sample_out)), y);
                chk("idle", int'(busy), 0);
                chk("wren_after", int'(mem_wren), 0);
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 70000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(busy), 0);
`ifdef ECHO_CLEAR_EN
        for (int i = 0; i < 65536; i++) ref_mem[i] = 0;
`endif
    endtask

    initial begin
        int s;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = '0;
            ref_mem[i] = 0;
        end
        resetn = 1'b0; sample_valid = 1'b0; sample_in = '0; delay = '0; feedback = '0;
        repeat (3) @(negedge clk);
        chk("rst_sample_out", int'(sample_out), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_wren", int'(mem_wren), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_datain", int'(mem_datain), 0);
        resetn = 1'b1;
`ifdef ECHO_CLEAR_EN
        @(negedge clk);
        chk("clr_busy", int'(busy), 1);
        chk("clr_wren", int'(mem_wren), 1);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("clr_overrun", int'(overrun), 1);
`endif
        wait_idle();

        // Impulse echo, then transparent path with zero gain.
        do_sample(1000, 4, 128, 0);
        for (int i = 0; i < 12; i++) do_sample(0, 4, 128, 0);
        for (int i = 0; i < 4; i++) do_sample(i * 1111 - 2000, 4, 0, 0);

        // Saturation both ways with near-unity feedback.
        for (int i = 0; i < 4; i++) do_sample(30000, 1, 255, 0);
        for (int i = 0; i < 4; i++) do_sample(-30000, 1, 255, 0);

        // Wrap at delay=3, then shrink the delay while ptr sits at 2.
        for (int i = 0; i < 8; i++) do_sample(i * 100, 3, 64, 0);
        for (int i = 0; i < 3; i++) do_sample(7, 1, 32, 0);

`ifndef ECHO_CLEAR_EN
        chk("overrun_clear", int'(overrun), 0);
`endif
        do_sample(123, 2, 100, 2);
        chk("overrun_set", int'(overrun), 1);
        do_sample(-5, 2, 100, 0);
        chk("overrun_sticky", int'(overrun), 1);

        // Reset asserted while the write is on the bus.
        sample_valid = 1'b1; sample_in = 16'd999; delay = 16'd5; feedback = 8'd10;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            sample_valid = 1'b0;
        end
        chk("pre_rst_wren", int'(mem_wren), 1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_wren", int'(mem_wren), 0);
        chk("mid_rst_addr", int'(mem_addr), 0);
        chk("mid_rst_out", int'(sample_out), 0);
        chk("mid_rst_ovalid", int'(out_valid), 0);
        chk("mid_rst_overrun", int'(overrun), 0);
        ref_ptr = 0;
        @(negedge clk);
        resetn = 1'b1;
        wait_idle();
        do_sample(42, 5, 10, 0);

        // Randomized traffic over short delays and full-scale samples.
        for (int i = 0; i < 200; i++) begin
            s = int'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 3) == 0) s = s / 64;
            do_sample(s, int'($urandom_range(0, 6)), int'($urandom_range(0, 255)),
                      ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
